// File: rtl/calc_sequencer_if.sv
`default_nettype none
// calc_sequencer_if: strobes, entry value and result/status signals between the
// input/display logic (master) and calc_sequencer (slave).
interface calc_sequencer_if #(
   parameter int WIDTH = 40
);
   logic             enter;
   logic [2:0]       op;
   logic             digit_in;
   logic             exe;
   logic             ce;
   logic [WIDTH-1:0] entry;
   logic             ext_ce;
   logic [WIDTH-1:0] display;
   logic             busy;
   logic             done;
   logic             ovf;
   logic [2:0]       state;

   modport master (
      output enter, op, digit_in, exe, ce, entry,
      input  ext_ce, display, busy, done, ovf, state
   );

   modport slave (
      input  enter, op, digit_in, exe, ce, entry,
      output ext_ce, display, busy, done, ovf, state
   );
endinterface
`default_nettype wire

// File: rtl/calc_sequencer.sv
`default_nettype none
// calc_sequencer: control FSM and private ALU for the hex calculator.
// Optional macro CALC_DIV_EN adds restoring division (op 6) and the S_ERR state.
module calc_sequencer #(
   parameter int WIDTH      = 40,
   parameter int MUL_CYCLES = 40
) (
   input  logic            clk,
   input  logic            reset,
   calc_sequencer_if.slave bus
);
   localparam int CNT_W = $clog2(MUL_CYCLES + 1);
   localparam logic [2:0] OP_ADD = 3'd1;
   localparam logic [2:0] OP_SUB = 3'd2;
   localparam logic [2:0] OP_MUL = 3'd3;
   localparam logic [2:0] OP_AND = 3'd4;
   localparam logic [2:0] OP_OR  = 3'd5;
`ifdef CALC_DIV_EN
   localparam logic [2:0] OP_DIV = 3'd6;
   typedef enum logic [2:0] {
      S_OPA = 3'd0, S_OPB = 3'd1, S_EXEC = 3'd2, S_RESULT = 3'd3, S_ERR = 3'd4
   } state_t;
`else
   typedef enum logic [2:0] {
      S_OPA = 3'd0, S_OPB = 3'd1, S_EXEC = 3'd2, S_RESULT = 3'd3
   } state_t;
`endif

   state_t           state_r, state_nx;
   logic [WIDTH-1:0] a_r, b_r, result_r, prod_hi_r, prod_lo_r;
   logic [2:0]       opcode_r;
   logic             ovf_r, ext_ce_r, done_r;
   logic [CNT_W-1:0] cnt_r;

   logic             opsel, op_ok, iterative, last_step;
   logic             clear, take_a, chain, take_op, take_b, finish, clr_ovf, ext_ce_nx;
   logic [WIDTH-1:0] step_hi, step_lo, alu_res;
   logic             alu_ovf;
   logic [WIDTH:0]   mul_sum, add_sum;

`ifdef CALC_DIV_EN
   logic [WIDTH:0]   div_shift, div_trial;
   assign op_ok     = (bus.op >= OP_ADD) && (bus.op <= OP_DIV);
   assign iterative = (opcode_r == OP_MUL) || (opcode_r == OP_DIV);
   assign div_shift = {prod_hi_r, prod_lo_r[WIDTH-1]};
   assign div_trial = div_shift - {1'b0, b_r};
`else
   assign op_ok     = (bus.op >= OP_ADD) && (bus.op <= OP_OR);
   assign iterative = (opcode_r == OP_MUL);
`endif

   assign opsel     = bus.enter && op_ok;
   assign last_step = (cnt_r == CNT_W'(MUL_CYCLES - 1));

   // Shift-add multiply: prod_hi accumulates, prod_lo holds the multiplier and
   // receives the low product bits as they shift out.
   assign mul_sum = {1'b0, prod_hi_r} + (prod_lo_r[0] ? {1'b0, a_r} : '0);
   assign add_sum = {1'b0, a_r} + {1'b0, b_r};

   always_comb begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], prod_lo_r[WIDTH-1:1]};
`ifdef CALC_DIV_EN
      // Restoring division: prod_hi is the partial remainder, prod_lo the quotient.
      if (opcode_r == OP_DIV) begin
         step_hi = div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
         step_lo = {prod_lo_r[WIDTH-2:0], ~div_trial[WIDTH]};
      end
`endif
   end

   always_comb begin
      alu_res = '0;
      alu_ovf = 1'b0;
      case (opcode_r)
         OP_ADD: begin
            alu_res = add_sum[WIDTH-1:0];
            alu_ovf = add_sum[WIDTH];
         end
         OP_SUB: begin
            alu_res = a_r - b_r;
            alu_ovf = (b_r > a_r);
         end
         OP_MUL: begin
            alu_res = step_lo;
            alu_ovf = |step_hi;
         end
         OP_AND: alu_res = a_r & b_r;
         OP_OR:  alu_res = a_r | b_r;
`ifdef CALC_DIV_EN
         OP_DIV: alu_res = step_lo;
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_r <= S_OPA;
      else       state_r <= state_nx;
   end

   always_comb begin
      state_nx  = state_r;
      clear     = 1'b0;
      take_a    = 1'b0;
      chain     = 1'b0;
      take_op   = 1'b0;
      take_b    = 1'b0;
      finish    = 1'b0;
      clr_ovf   = 1'b0;
      ext_ce_nx = 1'b0;
      if (bus.ce) begin
         clear    = 1'b1;
         state_nx = S_OPA;
      end else begin
         case (state_r)
            S_OPA: begin
               if (opsel) begin
                  take_a    = 1'b1;
                  take_op   = 1'b1;
                  ext_ce_nx = 1'b1;
                  state_nx  = S_OPB;
               end
            end
            S_OPB: begin
               if (opsel) begin
                  take_op = 1'b1;
               end else if (bus.exe) begin
                  take_b   = 1'b1;
                  state_nx = S_EXEC;
`ifdef CALC_DIV_EN
                  if ((opcode_r == OP_DIV) && (bus.entry == '0)) state_nx = S_ERR;
`endif
               end
            end
            S_EXEC: begin
               if (!iterative || last_step) begin
                  finish    = 1'b1;
                  ext_ce_nx = 1'b1;
                  state_nx  = S_RESULT;
               end
            end
            S_RESULT: begin
               if (opsel) begin
                  chain     = 1'b1;
                  take_op   = 1'b1;
                  clr_ovf   = 1'b1;
                  ext_ce_nx = 1'b1;
                  state_nx  = S_OPB;
               end else if (bus.digit_in) begin
                  clr_ovf  = 1'b1;
                  state_nx = S_OPA;
               end
            end
            default: state_nx = state_r;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_r       <= '0;
         b_r       <= '0;
         opcode_r  <= '0;
         result_r  <= '0;
         prod_hi_r <= '0;
         prod_lo_r <= '0;
         cnt_r     <= '0;
         ovf_r     <= 1'b0;
         ext_ce_r  <= 1'b0;
         done_r    <= 1'b0;
      end else begin
         ext_ce_r <= ext_ce_nx;
         done_r   <= finish;
         if (clear) begin
            a_r      <= '0;
            b_r      <= '0;
            opcode_r <= '0;
            result_r <= '0;
            cnt_r    <= '0;
            ovf_r    <= 1'b0;
         end else begin
            if (take_a)  a_r      <= bus.entry;
            if (chain)   a_r      <= result_r;
            if (take_op) opcode_r <= bus.op;
            if (clr_ovf) ovf_r    <= 1'b0;
            if (take_b) begin
               b_r       <= bus.entry;
               prod_hi_r <= '0;
               prod_lo_r <= bus.entry;
               cnt_r     <= '0;
`ifdef CALC_DIV_EN
               if (opcode_r == OP_DIV) prod_lo_r <= a_r;
               if ((opcode_r == OP_DIV) && (bus.entry == '0)) ovf_r <= 1'b1;
`endif
            end
            if (state_r == S_EXEC) begin
               prod_hi_r <= step_hi;
               prod_lo_r <= step_lo;
               cnt_r     <= cnt_r + CNT_W'(1);
            end
            if (finish) begin
               result_r <= alu_res;
               ovf_r    <= alu_ovf;
            end
         end
      end
   end

   always_comb begin
      bus.display = bus.entry;
      case (state_r)
         S_EXEC:   bus.display = b_r;
         S_RESULT: bus.display = result_r;
`ifdef CALC_DIV_EN
         S_ERR:    bus.display = '1;
`endif
         default:  bus.display = bus.entry;
      endcase
   end

   assign bus.ext_ce = ext_ce_r;
   assign bus.done   = done_r;
   assign bus.ovf    = ovf_r;
   assign bus.busy   = (state_r == S_EXEC);
   assign bus.state  = state_r;
endmodule
`default_nettype wire
